// File: rtl/pmp_csr.sv
// PMP configuration/address CSR block: pmpcfg0/2 and pmpaddrN with lock and TOR
// write protection, a one-deep request/response handshake and a flush pulse on change.
package pmp_csr_pkg;
    typedef struct packed {
        logic       lock;
        logic [1:0] rsvd;
        logic [1:0] mode;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    localparam logic [1:0] MODE_TOR = 2'd1;
endpackage

module pmp_entry
    import pmp_csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  pmp_cfg_t    cfg_wdata,
    input  logic        addr_we,
    input  logic [53:0] addr_wdata,
    output pmp_cfg_t    cfg,
    output logic [53:0] addr,
    output logic        changed
);
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg  <= '0;
            addr <= '0;
        end else begin
            if (cfg_we)  cfg  <= cfg_wdata;
            if (addr_we) addr <= addr_wdata;
        end
    end

    assign changed = (cfg_we && (cfg_wdata != cfg)) || (addr_we && (addr_wdata != addr));
endmodule

module pmp_csr
    import pmp_csr_pkg::*;
#(
    parameter int REGION_COUNT = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_req_valid,
    output logic                               o_req_ready,
    input  logic [11:0]                        i_req_addr,
    input  logic                               i_req_write,
    input  logic [63:0]                        i_req_wdata,
    output logic                               o_resp_valid,
    input  logic                               i_resp_ready,
    output logic [63:0]                        o_resp_rdata,
    output logic                               o_resp_illegal,
    output pmp_cfg_t [REGION_COUNT-1:0]        o_pmp_cfg,
    output logic [REGION_COUNT-1:0][55:0]      o_pmp_addr,
    output logic                               o_pmp_flush
);
    localparam int AW = $clog2(REGION_COUNT);

    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nxt;

    pmp_cfg_t [REGION_COUNT-1:0]         cfg_q;
    logic     [REGION_COUNT-1:0][53:0]   addr_q;
    logic     [REGION_COUNT-1:0]         changed;
    logic     [63:0]                     cfg_lo, cfg_hi, rd_data;
    logic     [AW-1:0]                   addr_idx;
    logic accept, wr, sel_cfg0, sel_cfg2, sel_addr, legal;

    assign accept   = i_req_valid && (state == IDLE);
    assign wr       = accept && i_req_write;
    assign sel_cfg0 = (i_req_addr == 12'h3A0);
    assign sel_cfg2 = (REGION_COUNT == 16) && (i_req_addr == 12'h3A2);
    assign sel_addr = (i_req_addr[11:4] == 8'h3B) && ((REGION_COUNT == 16) || !i_req_addr[3]);
    assign legal    = sel_cfg0 || sel_cfg2 || sel_addr;
    assign addr_idx = i_req_addr[AW-1:0];

    assign cfg_lo = cfg_q[7:0];
    if (REGION_COUNT == 16) begin : g_cfg_hi
        assign cfg_hi = cfg_q[15:8];
    end else begin : g_no_cfg_hi
        assign cfg_hi = '0;
    end

    always_comb begin
        rd_data = '0;
        if (sel_cfg0)      rd_data = cfg_lo;
        else if (sel_cfg2) rd_data = cfg_hi;
        else if (sel_addr) rd_data = {10'b0, addr_q[addr_idx]};
    end

    for (genvar e = 0; e < REGION_COUNT; e++) begin : g_entry
        logic [7:0] wbyte;
        logic       cfg_sel, tor_lock, cfg_we, addr_we;
        pmp_cfg_t   cfg_new;

        assign wbyte   = i_req_wdata[(e % 8) * 8 +: 8];
        assign cfg_sel = (e < 8) ? sel_cfg0 : sel_cfg2;
        assign cfg_new = {wbyte[7], 2'b00, wbyte[4:0]};
        // R=0/W=1 is reserved: that byte is dropped, its neighbours still land
        assign cfg_we  = wr && cfg_sel && !cfg_q[e].lock && !(!wbyte[0] && wbyte[1]);

        // A locked TOR entry above also freezes this entry's address (its lower bound)
        if (e + 1 < REGION_COUNT) begin : g_nb
            assign tor_lock = cfg_q[e+1].lock && (cfg_q[e+1].mode == MODE_TOR);
        end else begin : g_last
            assign tor_lock = 1'b0;
        end
        assign addr_we = wr && sel_addr && (addr_idx == AW'(e)) && !cfg_q[e].lock && !tor_lock;

        pmp_entry u_entry (
            .clk        (i_clk),
            .rst        (i_rst),
            .cfg_we     (cfg_we),
            .cfg_wdata  (cfg_new),
            .addr_we    (addr_we),
            .addr_wdata (i_req_wdata[53:0]),
            .cfg        (cfg_q[e]),
            .addr       (addr_q[e]),
            .changed    (changed[e])
        );

        assign o_pmp_cfg[e]  = cfg_q[e];
        assign o_pmp_addr[e] = {addr_q[e], 2'b00};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_req_valid)  state_nxt = RESP;
            RESP: if (i_resp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            o_resp_rdata   <= '0;
            o_resp_illegal <= 1'b0;
            o_pmp_flush    <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_pmp_flush <= |changed;
            if (accept) begin
                o_resp_rdata   <= rd_data;
                o_resp_illegal <= !legal;
            end
        end
    end

    assign o_req_ready  = (state == IDLE);
    assign o_resp_valid = (state == RESP);
endmodule

// File: doc/pmp_csr.md
PMP_CSR -- requirements
Module: pmp_csr

Interface
REQ-001 Parameter REGION_COUNT, default 16, number of PMP entries; legal values 8 or 16.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port i_clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  synchronous active-high reset.
REQ-005 Port i_req_valid  input  1  CSR access request present.
REQ-006 Port o_req_ready  output  1  request accepted this cycle when high together with i_req_valid.
REQ-007 Port i_req_addr  input  12  CSR number.
REQ-008 Port i_req_write  input  1  1 = write (old value returned), 0 = read only.
REQ-009 Port i_req_wdata  input  64  write data.
REQ-010 Port o_resp_valid  output  1  response present.
REQ-011 Port i_resp_ready  input  1  response consumed when high together with o_resp_valid.
REQ-012 Port o_resp_rdata  output  64  pre-write CSR value; 0 when illegal.
REQ-013 Port o_resp_illegal  output  1  CSR number not implemented.
REQ-014 Port o_pmp_cfg  output  pmp_cfg_t[REGION_COUNT]  live entry configuration to the PMP checker.
REQ-015 Port o_pmp_addr  output  56[REGION_COUNT]  live entry address, {pmpaddr[53:0], 2'b00}.
REQ-016 Port o_pmp_flush  output  1  one-cycle pulse after any write that changed cfg or addr state.

Function
REQ-017 CSR map: pmpcfg0 = 0x3A0 (entries 0-7), pmpcfg2 = 0x3A2 (entries 8-15, only if REGION_COUNT = 16), pmpaddrN = 0x3B0+N for N < REGION_COUNT; every other number is illegal.
REQ-018 Cfg byte layout: bit0 read, bit1 write, bit2 exec, bits4:3 mode (OFF/TOR/NA4/NAPOT), bits6:5 read as 0, bit7 lock.
REQ-019 pmpaddr storage is 54 bits; write takes wdata[53:0]; read returns {10'b0, value}.
REQ-020 FSM states: IDLE, RESP; o_req_ready = 1 only in IDLE.
REQ-021 IDLE -> RESP on i_req_valid accepted; RESP -> IDLE on i_resp_ready; RESP holds all response outputs stable.
REQ-022 Latency: request accepted in cycle N -> o_resp_valid and updated o_pmp_cfg/o_pmp_addr visible in cycle N+1.
REQ-023 Write side effects apply exactly once, in the accept cycle; illegal writes change no state.
REQ-024 A cfg byte is written only if its stored lock bit is 0; locked bytes keep their value.
REQ-025 A cfg byte write with read=0 and write=1 (reserved combination) is ignored for that byte; other bytes of the same write still apply.
REQ-026 pmpaddrN write ignored if cfg[N].lock = 1, or if N+1 < REGION_COUNT with cfg[N+1].lock = 1 and cfg[N+1].mode = TOR.
REQ-027 Lock is sticky: once set, cleared only by reset.
REQ-028 o_pmp_flush asserts in cycle N+1 for exactly one cycle iff the accepted write changed any stored bit; reads and no-op writes give no pulse.
REQ-029 Lock/TOR checks use state before the write; a single pmpcfg write setting lock and a pmpaddr write in the next request: the pmpaddr write is blocked.

Reset
REQ-030 On i_rst: state IDLE, all cfg bytes 0 (mode OFF, lock 0), all pmpaddr 0, o_resp_valid 0, o_resp_rdata 0, o_resp_illegal 0, o_pmp_flush 0, o_req_ready 1 in the following cycle.
REQ-031 Reset while in RESP drops the pending response with no further side effects.

Verification
REQ-032 Write 0x3A0 wdata 0x0000_0000_0000_001F -> resp rdata 0, cfg[0] = NAPOT/RWX unlocked, flush pulse 1 cycle, cfg[1..7] mode OFF.
REQ-033 Write 0x3A0 byte0 = 0x8F (lock, TOR, RWX), then write 0x3A0 byte0 = 0x00 -> second resp rdata byte0 = 0x8F, cfg[0] unchanged, no flush.
REQ-034 cfg[1] = 0x89 (lock, TOR, R); write 0x3B0 = 0x1234 -> pmpaddr0 stays 0; write 0x3B1 = 0x1234 -> blocked; write 0x3B2 = 0x1234 -> o_pmp_addr[2] = 0x48D0.
REQ-035 Write 0x3A0 byte0 = 0x02 (W without R) and byte1 = 0x19 -> cfg[0] unchanged, cfg[1] = NAPOT/R.
REQ-036 Read 0x3A1 and 0x3C0 -> o_resp_illegal 1, rdata 0, no state change; hold i_resp_ready low 3 cycles -> response stable, o_req_ready 0 throughout.
REQ-037 Assert i_rst during RESP -> o_resp_valid 0 next cycle, all cfg/addr outputs 0.
